// File: rtl/truth_table_scanner.sv
// Truth-table scanner: steps an N-variable target through every input vector in
// ascending order, holds each one for SETTLE_CYCLES+1 cycles, and records the minterm mask and counts.
module truth_table_scanner #(
  parameter int N_VARS        = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic [N_VARS-1:0]      vars_out,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [2**N_VARS-1:0]   minterm_mask,
  output logic [N_VARS:0]        minterm_count,
  output logic [N_VARS:0]        maxterm_count
);

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  state_t            state, state_next;
  logic [N_VARS-1:0] index;
  logic [3:0]        settle;
  logic              capture;
  logic              last;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    capture    = 1'b0;
    last       = (index == '1);
    case (state)
      IDLE: if (start) state_next = HOLD;
      HOLD: begin
        capture = (settle == SETTLE_LAST);
        if (capture && last) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The exit test precedes the increment, so the index never wraps past all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      index         <= '0;
      settle        <= '0;
      minterm_mask  <= '0;
      minterm_count <= '0;
      maxterm_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            index         <= '0;
            settle        <= '0;
            minterm_mask  <= '0;
            minterm_count <= '0;
            maxterm_count <= '0;
          end
        end
        HOLD: begin
          if (capture) begin
            minterm_mask[index] <= f_in;
            minterm_count       <= minterm_count + {{N_VARS{1'b0}}, f_in};
            maxterm_count       <= maxterm_count + {{N_VARS{1'b0}}, ~f_in};
            settle              <= '0;
            if (!last) index <= index + 1'b1;
          end else begin
            settle <= settle + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign vars_out = (state == HOLD) ? index : '0;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: three instances (S=2, S=0, S=1) driven from a
// vector table, with expected scan results held in a scoreboard queue until done.
module tb_truth_table_scanner;

  typedef struct {
    int unsigned sel;
    logic [15:0] mask;
    logic [4:0]  minc;
    logic [4:0]  maxc;
  } exp_t;

  typedef struct {
    int unsigned sel;
    int unsigned mode;
    logic [15:0] mask;
    logic [4:0]  minc;
    logic [4:0]  maxc;
    int unsigned lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic f_a, f_b, f_c;
  logic [3:0]  vars_a, vars_b, vars_c;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic [15:0] mask_a, mask_b, mask_c;
  logic [4:0]  minc_a, minc_b, minc_c, maxc_a, maxc_b, maxc_c;
  logic d1_a = 1'b0, d2_a = 1'b0, d1_c = 1'b0, d2_c = 1'b0;

  int unsigned fmode = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  exp_t sb[$];
  exp_t mon_e;
  int unsigned mon_s;
  vec_t vecs[6];

  always #5 clk = ~clk;

  truth_table_scanner #(.N_VARS(4), .SETTLE_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .vars_out(vars_a), .f_in(f_a),
    .busy(busy_a), .done(done_a), .minterm_mask(mask_a),
    .minterm_count(minc_a), .maxterm_count(maxc_a));

  truth_table_scanner #(.N_VARS(4), .SETTLE_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .vars_out(vars_b), .f_in(f_b),
    .busy(busy_b), .done(done_b), .minterm_mask(mask_b),
    .minterm_count(minc_b), .maxterm_count(maxc_b));

  truth_table_scanner #(.N_VARS(4), .SETTLE_CYCLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .vars_out(vars_c), .f_in(f_c),
    .busy(busy_c), .done(done_c), .minterm_mask(mask_c),
    .minterm_count(minc_c), .maxterm_count(maxc_c));

  // Two-register delay of vars_out[0], standing in for a slow target.
  always @(posedge clk) begin
    d1_a <= vars_a[0];
    d2_a <= d1_a;
    d1_c <= vars_c[0];
    d2_c <= d1_c;
  end

  // Mode 0: PoS with maxterms 0,1,2,6,15; 1: const 0; 2: const 1; 3: a; 4: delayed d.
  function automatic logic fval(input int unsigned m, input logic [3:0] v, input logic d);
    case (m)
      0: fval = !(v == 4'd0 || v == 4'd1 || v == 4'd2 || v == 4'd6 || v == 4'd15);
      1: fval = 1'b0;
      2: fval = 1'b1;
      3: fval = v[3];
      default: fval = d;
    endcase
  endfunction

  assign f_a = fval(fmode, vars_a, d2_a);
  assign f_b = fval(fmode, vars_b, 1'b0);
  assign f_c = fval(fmode, vars_c, d2_c);

  function automatic logic done_of(input int unsigned s);
    case (s) 0: done_of = done_a; 1: done_of = done_b; default: done_of = done_c; endcase
  endfunction
  function automatic logic busy_of(input int unsigned s);
    case (s) 0: busy_of = busy_a; 1: busy_of = busy_b; default: busy_of = busy_c; endcase
  endfunction
  function automatic logic [3:0] vars_of(input int unsigned s);
    case (s) 0: vars_of = vars_a; 1: vars_of = vars_b; default: vars_of = vars_c; endcase
  endfunction
  function automatic logic [15:0] mask_of(input int unsigned s);
    case (s) 0: mask_of = mask_a; 1: mask_of = mask_b; default: mask_of = mask_c; endcase
  endfunction
  function automatic logic [4:0] minc_of(input int unsigned s);
    case (s) 0: minc_of = minc_a; 1: minc_of = minc_b; default: minc_of = minc_c; endcase
  endfunction
  function automatic logic [4:0] maxc_of(input int unsigned s);
    case (s) 0: maxc_of = maxc_a; 1: maxc_of = maxc_b; default: maxc_of = maxc_c; endcase
  endfunction

  task automatic set_start(input int unsigned s, input logic val);
    case (s) 0: start_a = val; 1: start_b = val; default: start_c = val; endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input int unsigned s);
    check("rst_vars", 64'(vars_of(s)), 64'd0);
    check("rst_mask", 64'(mask_of(s)), 64'd0);
    check("rst_minc", 64'(minc_of(s)), 64'd0);
    check("rst_maxc", 64'(maxc_of(s)), 64'd0);
    check("rst_busy", 64'(busy_of(s)), 64'd0);
    check("rst_done", 64'(done_of(s)), 64'd0);
  endtask

  // Scoreboard: every done pulse retires the oldest expected result.
  always @(negedge clk) begin
    if (done_a || done_b || done_c) begin
      mon_s = done_a ? 0 : (done_b ? 1 : 2);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected_done actual=dut%0d required=none at %0t", mon_s, $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_dut",  64'(mon_s), 64'(mon_e.sel));
        check("sb_mask", 64'(mask_of(mon_s)), 64'(mon_e.mask));
        check("sb_minc", 64'(minc_of(mon_s)), 64'(mon_e.minc));
        check("sb_maxc", 64'(maxc_of(mon_s)), 64'(mon_e.maxc));
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int unsigned cyc;
    int unsigned busy_low;
    logic seen;
    fmode = v.mode;
    @(negedge clk);
    set_start(v.sel, 1'b1);
    sb.push_back('{sel: v.sel, mask: v.mask, minc: v.minc, maxc: v.maxc});
    cyc = 0;
    busy_low = 0;
    seen = 1'b0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      set_start(v.sel, 1'b0);
      cyc++;
      if (v.sel == 1 && cyc <= 16) check("vars_step", 64'(vars_of(1)), 64'(cyc - 1));
      if (done_of(v.sel)) seen = 1'b1;
      else if (!busy_of(v.sel)) busy_low++;
    end
    check("done_latency", 64'(cyc), 64'(v.lat));
    check("busy_during_scan", 64'(busy_low), 64'd0);
    @(negedge clk);
    check("done_one_cycle", 64'(done_of(v.sel)), 64'd0);
    check("idle_after_done", 64'(busy_of(v.sel)), 64'd0);
    check("result_hold", 64'(mask_of(v.sel)), 64'(v.mask));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    logic exp_busy, exp_done;

    vecs[0] = '{sel: 0, mode: 0, mask: 16'h7FB8, minc: 5'd11, maxc: 5'd5,  lat: 49};
    vecs[1] = '{sel: 0, mode: 1, mask: 16'h0000, minc: 5'd0,  maxc: 5'd16, lat: 49};
    vecs[2] = '{sel: 0, mode: 2, mask: 16'hFFFF, minc: 5'd16, maxc: 5'd0,  lat: 49};
    vecs[3] = '{sel: 1, mode: 3, mask: 16'hFF00, minc: 5'd8,  maxc: 5'd8,  lat: 17};
    vecs[4] = '{sel: 0, mode: 4, mask: 16'hAAAA, minc: 5'd8,  maxc: 5'd8,  lat: 49};
    // S=1 samples the bit of the previous index: bits 2,4,..,14 set.
    vecs[5] = '{sel: 2, mode: 4, mask: 16'h5554, minc: 5'd7,  maxc: 5'd9,  lat: 33};

    repeat (3) @(negedge clk);
    for (int unsigned s = 0; s < 3; s++) check_all_zero(s);
    rst_n = 1'b1;

    for (int unsigned i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset mid-scan at index 5, then a clean rescan.
    fmode = 0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 1'b0;
    for (int unsigned k = 0; k < 100 && !found; k++) begin
      if (vars_a == 4'd5) found = 1'b1;
      else @(negedge clk);
    end
    check("reach_index5", 64'(found), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_all_zero(0);
    run_vec(vecs[0]);

    // start held high: scans back to back with a single IDLE cycle between.
    fmode = 0;
    @(negedge clk);
    start_a = 1'b1;
    for (int unsigned k = 0; k < 3; k++)
      sb.push_back('{sel: 0, mask: 16'h7FB8, minc: 5'd11, maxc: 5'd5});
    for (int unsigned cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      exp_done = (cyc == 49 || cyc == 99);
      exp_busy = !(cyc == 50 || cyc == 100);
      check("held_done", 64'(done_a), 64'(exp_done));
      check("held_busy", 64'(busy_a), 64'(exp_busy));
    end
    start_a = 1'b0;
    found = 1'b0;
    for (int unsigned k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (done_a) found = 1'b1;
    end
    check("third_scan_done", 64'(found), 64'd1);

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential characteriser for small combinational logic blocks of the PoS/SoP kind built in this course tree.
- Drives every input combination of an N-variable function in ascending binary order and samples the function output after a settle delay.
- Produces the minterm mask and the minterm/maxterm counts in hardware. This replaces the hand-written truth-table testbench sweep.
- Sits between a start/done controller and the device under characterisation.

Parameters:
- N_VARS, 4, number of function inputs; range 1..6.
- SETTLE_CYCLES, 2, clock cycles each input vector is held before sampling; range 0..15.

Ports:
- clk  input  1  single system clock; all logic is on the rising edge.
- rst_n  input  1  reset, synchronous to clk, active-low.
- start  input  1  request a scan; sampled only in IDLE.
- vars_out  output  N_VARS  vector applied to the target; vars_out[N_VARS-1] is variable a (MSB), vars_out[0] is the last variable.
- f_in  input  1  target function output.
- busy  output  1  high from the cycle after start is accepted through the cycle done is high.
- done  output  1  one-cycle pulse; results are valid in that cycle.
- minterm_mask  output  2**N_VARS  bit i = f_in sampled while vars_out == i.
- minterm_count  output  N_VARS+1  number of 1 bits in minterm_mask.
- maxterm_count  output  N_VARS+1  2**N_VARS minus minterm_count.

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE.
  - vars_out, minterm_mask, minterm_count, maxterm_count, busy and done all go to 0.
  - Reset overrides every other event, including mid-scan; a partial scan is discarded.
- States: IDLE, HOLD, DONE.
- IDLE:
  - vars_out = 0.
  - On start = 1: clear mask, both counts and index; settle counter = 0; go to HOLD.
  - Otherwise results hold their last values.
- HOLD:
  - vars_out = index; each index occupies exactly SETTLE_CYCLES+1 cycles.
  - Settle counter increments each cycle.
  - When the counter equals SETTLE_CYCLES, f_in is captured at that edge:
    - minterm_mask[index] <= f_in.
    - minterm_count += f_in.
    - maxterm_count += ~f_in.
  - After a capture, if index == 2**N_VARS-1, go to DONE. Otherwise index+1 and the counter resets to 0.
  - With SETTLE_CYCLES = 0, one vector is captured per cycle.
- DONE:
  - done = 1 and busy = 1 for exactly one cycle, then go to IDLE.
  - Results are stable from DONE until the next accepted start.
- Latency: start accepted at edge E0; the final capture occurs at edge E0 + 2**N_VARS × (SETTLE_CYCLES+1); done is high in the following cycle.
  - For N=4, S=2: 48 cycles of HOLD, done in cycle 49.
- start asserted during HOLD or DONE is ignored; there is no queuing.
- start held high continuously: the next scan is accepted in the first IDLE cycle after DONE, so consecutive scans are separated by exactly one IDLE cycle.
- Index counter is N_VARS bits wide. It never wraps, because the exit condition is checked before increment.
- Count registers are N_VARS+1 bits and reach 2**N_VARS without overflow.
- f_in is treated as synchronous to clk. X/Z on f_in is captured as-is; no filtering.

Test Plan:
1. N=4, S=2, f_in from the 4-input PoS function with maxterms 0,1,2,6,15, start pulsed.
   - done fires 49 cycles after start.
   - minterm_mask = 16'h7FB8, minterm_count = 11, maxterm_count = 5.
   - Sampled entries 0..7 read 0,0,0,1,1,1,0,1.
2. f_in tied 0, then a second scan with f_in tied 1.
   - First scan: mask = 16'h0000, maxterm_count = 16.
   - Second scan: mask = 16'hFFFF, minterm_count = 16, maxterm_count = 0.
3. f_in = vars_out[3] (function = a), S=0.
   - mask = 16'hFF00, counts 8/8.
   - done 17 cycles after start; vars_out steps 0..15 on consecutive cycles.
4. Settle check, S=2, f_in = vars_out[0] delayed by 2 registers.
   - Mask = 16'hAAAA, proving sampling occurs after SETTLE_CYCLES.
   - With S=1 and the same delay, the mask differs from 16'hAAAA.
5. rst_n low for one cycle while index = 5 mid-scan.
   - Next cycle: all outputs 0, state IDLE.
   - A new start yields a correct full scan (mask 16'h7FB8 with the test-1 function).
6. start held high for 120 cycles, N=4, S=2.
   - done pulses in cycle 49 and cycle 99 (one IDLE cycle between scans).
   - busy is low only in the IDLE gap cycle; extra start pulses during HOLD do not restart the index.
